// File: rtl/multicycle_ctrl.sv
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Multicycle MIPS-subset control unit (IF/ID/EXE/MEM/WB/HALT)
//                with a retired-instruction counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
  parameter int ILLEGAL_TRAP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_rd,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [1:0]  ext_op,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_we,
  output logic        halted,
  output logic [31:0] retired
);

  localparam logic [5:0] c_OP_R    = 6'b000000;
  localparam logic [5:0] c_OP_ADDI = 6'b001000;
  localparam logic [5:0] c_OP_ANDI = 6'b001100;
  localparam logic [5:0] c_OP_ORI  = 6'b001101;
  localparam logic [5:0] c_OP_LUI  = 6'b001111;
  localparam logic [5:0] c_OP_LW   = 6'b100011;
  localparam logic [5:0] c_OP_SW   = 6'b101011;
  localparam logic [5:0] c_OP_BEQ  = 6'b000100;
  localparam logic [5:0] c_OP_J    = 6'b000010;

  localparam logic [5:0] c_FN_ADD  = 6'b100000;
  localparam logic [5:0] c_FN_SUB  = 6'b100010;
  localparam logic [5:0] c_FN_AND  = 6'b100100;
  localparam logic [5:0] c_FN_OR   = 6'b100101;
  localparam logic [5:0] c_FN_SLT  = 6'b101010;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t      r_state;
  logic [31:0] r_retired;

  logic       w_is_r, w_is_addi, w_is_andi, w_is_ori, w_is_lui;
  logic       w_is_lw, w_is_sw, w_is_beq, w_is_j;
  logic       w_funct_ok, w_legal;
  logic [1:0] w_ext;
  logic [2:0] w_alu_op;
  logic       w_alu_src;
  logic       w_retire;

  assign w_is_r    = (opcode == c_OP_R);
  assign w_is_addi = (opcode == c_OP_ADDI);
  assign w_is_andi = (opcode == c_OP_ANDI);
  assign w_is_ori  = (opcode == c_OP_ORI);
  assign w_is_lui  = (opcode == c_OP_LUI);
  assign w_is_lw   = (opcode == c_OP_LW);
  assign w_is_sw   = (opcode == c_OP_SW);
  assign w_is_beq  = (opcode == c_OP_BEQ);
  assign w_is_j    = (opcode == c_OP_J);

  assign w_funct_ok = (funct == c_FN_ADD) || (funct == c_FN_SUB) ||
                      (funct == c_FN_AND) || (funct == c_FN_OR)  ||
                      (funct == c_FN_SLT);

  assign w_legal = (w_is_r && w_funct_ok) || w_is_addi || w_is_andi ||
                   w_is_ori || w_is_lui || w_is_lw || w_is_sw ||
                   w_is_beq || w_is_j;

  // Per-instruction datapath selects, valid whenever opcode/funct are valid
  always_comb begin
    w_ext     = 2'b00;
    w_alu_op  = 3'b000;
    w_alu_src = w_is_addi | w_is_andi | w_is_ori | w_is_lui | w_is_lw | w_is_sw;
    if (w_is_addi || w_is_lw || w_is_sw || w_is_beq) w_ext = 2'b01;
    else if (w_is_lui)                               w_ext = 2'b10;
    if (w_is_r) begin
      case (funct)
        c_FN_SUB: w_alu_op = 3'b001;
        c_FN_AND: w_alu_op = 3'b010;
        c_FN_OR:  w_alu_op = 3'b011;
        c_FN_SLT: w_alu_op = 3'b100;
        default:  w_alu_op = 3'b000;
      endcase
    end else if (w_is_andi) w_alu_op = 3'b010;
    else if (w_is_ori)      w_alu_op = 3'b011;
    else if (w_is_beq)      w_alu_op = 3'b001;
  end

  // Output decode from current state; forced to zero while reset is held so
  // an in-flight write is cut off the instant rst_n falls
  always_comb begin
    mem_rd     = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    ext_op     = 2'b00;
    alu_src    = 1'b0;
    alu_op     = 3'b000;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_we     = 1'b0;
    w_retire   = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_IF: begin
          mem_rd = 1'b1;
          ir_we  = mem_ready;
          pc_we  = mem_ready;
        end
        S_ID: begin
          ext_op = w_ext;
          if (w_is_j) begin
            pc_we    = 1'b1;
            pc_src   = 2'b10;
            w_retire = 1'b1;
          end
        end
        S_EXE: begin
          ext_op  = w_ext;
          alu_src = w_alu_src;
          alu_op  = w_alu_op;
          if (w_is_beq) begin
            pc_we    = zero;
            pc_src   = 2'b01;
            w_retire = 1'b1;
          end
        end
        S_MEM: begin
          ext_op   = w_ext;
          mem_rd   = w_is_lw;
          mem_we   = w_is_sw;
          w_retire = w_is_sw & mem_ready;
        end
        S_WB: begin
          ext_op     = w_ext;
          reg_we     = 1'b1;
          reg_dst    = w_is_r;
          mem_to_reg = w_is_lw;
          w_retire   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign halted  = (r_state == S_HALT);
  assign retired = r_retired;

  // State sequencing and retired-instruction counter (wraps silently)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IF;
      r_retired <= 32'd0;
    end else begin
      if (w_retire) r_retired <= r_retired + 32'd1;
      case (r_state)
        S_IF:  if (mem_ready) r_state <= S_ID;
        S_ID: begin
          if (!w_legal)    r_state <= (ILLEGAL_TRAP != 0) ? S_HALT : S_IF;
          else if (w_is_j) r_state <= S_IF;
          else             r_state <= S_EXE;
        end
        S_EXE: begin
          if (w_is_beq)              r_state <= S_IF;
          else if (w_is_lw || w_is_sw) r_state <= S_MEM;
          else                       r_state <= S_WB;
        end
        S_MEM: if (mem_ready) r_state <= w_is_lw ? S_WB : S_IF;
        S_WB:   r_state <= S_IF;
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_IF;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Self-checking bench for multicycle_ctrl. An instruction-level
//                model expands each instruction into its expected per-cycle
//                output trace; a compare process checks every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI = 6'b001101, OP_LUI = 6'b001111, OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR = 6'b100101, FN_SLT = 6'b101010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_rd, mem_we, ir_we, pc_we, alu_src, reg_dst, mem_to_reg, reg_we, halted;
  logic [1:0]  pc_src, ext_op;
  logic [2:0]  alu_op;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [31:0] exp_ret = 32'd0;
  logic [47:0] exp_q[$];

  multicycle_ctrl #(.ILLEGAL_TRAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_we(mem_we), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .ext_op(ext_op), .alu_src(alu_src),
    .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_we(reg_we), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Packed output vector: rd we ir pcw pcsrc ext asrc aop rdst m2r rwe halt
  function automatic logic [15:0] mk(input logic rd, input logic we, input logic irw,
      input logic pcw, input logic [1:0] ps, input logic [1:0] ex, input logic as,
      input logic [2:0] ao, input logic rdst, input logic m2r, input logic rwe,
      input logic hlt);
    return {rd, we, irw, pcw, ps, ex, as, ao, rdst, m2r, rwe, hlt};
  endfunction

  function automatic logic [15:0] act_vec();
    return {mem_rd, mem_we, ir_we, pc_we, pc_src, ext_op, alu_src, alu_op,
            reg_dst, mem_to_reg, reg_we, halted};
  endfunction

  // Instruction-set rules
  function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == OP_R)
      return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    return op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J};
  endfunction

  function automatic logic [1:0] ext_of(input logic [5:0] op);
    if (op inside {OP_ADDI, OP_LW, OP_SW, OP_BEQ}) return 2'b01;
    if (op == OP_LUI) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [2:0] aluop_of(input logic [5:0] op, input logic [5:0] fn);
    if (op == OP_R) return (fn == FN_SUB) ? 3'd1 : (fn == FN_AND) ? 3'd2 :
                           (fn == FN_OR) ? 3'd3 : (fn == FN_SLT) ? 3'd4 : 3'd0;
    if (op == OP_ANDI) return 3'd2;
    if (op == OP_ORI)  return 3'd3;
    if (op == OP_BEQ)  return 3'd1;
    return 3'd0;
  endfunction

  // One cycle of stimulus: drive mem_ready, post the expected outputs
  task automatic step(input logic [15:0] e, input logic rdy, input bit retire_after);
    mem_ready = rdy;
    exp_q.push_back({exp_ret, e});
    if (retire_after) exp_ret = exp_ret + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int if_wait, input int mem_wait, input bit abort);
    logic [1:0] ex;
    bit         is_mem;
    opcode = op; funct = fn; zero = z;
    ex = ext_of(op);
    is_mem = (op == OP_LW) || (op == OP_SW);
    for (int i = 0; i < if_wait; i++) step(mk(1,0,0,0,2'd0,2'd0,0,3'd0,0,0,0,0), 1'b0, 0);
    step(mk(1,0,1,1,2'd0,2'd0,0,3'd0,0,0,0,0), 1'b1, 0);
    if (!legal(op, fn)) begin
      step(mk(0,0,0,0,2'd0,2'd0,0,3'd0,0,0,0,0), 1'($urandom_range(0,1)), 0);
      for (int i = 0; i < 20; i++)
        step(mk(0,0,0,0,2'd0,2'd0,0,3'd0,0,0,0,1), 1'($urandom_range(0,1)), 0);
      return;
    end
    if (op == OP_J) begin
      step(mk(0,0,0,1,2'b10,2'd0,0,3'd0,0,0,0,0), 1'($urandom_range(0,1)), 1);
      return;
    end
    step(mk(0,0,0,0,2'd0,ex,0,3'd0,0,0,0,0), 1'($urandom_range(0,1)), 0);
    if (op == OP_BEQ) begin
      step(mk(0,0,0,z,2'b01,ex,0,aluop_of(op,fn),0,0,0,0), 1'($urandom_range(0,1)), 1);
      return;
    end
    step(mk(0,0,0,0,2'd0,ex,(op != OP_R),aluop_of(op,fn),0,0,0,0),
         1'($urandom_range(0,1)), 0);
    if (is_mem) begin
      for (int i = 0; i < mem_wait; i++)
        step(mk(op == OP_LW, op == OP_SW,0,0,2'd0,ex,0,3'd0,0,0,0,0), 1'b0, 0);
      if (abort) return;
      step(mk(op == OP_LW, op == OP_SW,0,0,2'd0,ex,0,3'd0,0,0,0,0), 1'b1, op == OP_SW);
      if (op == OP_SW) return;
    end
    step(mk(0,0,0,0,2'd0,ex,0,3'd0,(op == OP_R),(op == OP_LW),1,0),
         1'($urandom_range(0,1)), 1);
  endtask

  // Compare process: every cycle with a posted expectation is checked mid-cycle
  always @(negedge clk) begin
    logic [47:0] e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("outputs", {16'd0, act_vec()}, {16'd0, e[15:0]});
      chk("retired", retired, e[47:16]);
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("reset_outputs", {16'd0, act_vec()}, 32'd0);
    chk("reset_retired", retired, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_instr(OP_R, FN_ADD, 0, 0, 0, 0);
    chk("add_retired", retired, 32'd1);
    run_instr(OP_LW, 6'd0, 0, 2, 3, 0);
    chk("lw_retired", retired, 32'd2);
    run_instr(OP_BEQ, 6'd0, 1, 0, 0, 0);
    run_instr(OP_BEQ, 6'd0, 0, 1, 0, 0);
    chk("beq_retired", retired, 32'd4);
    run_instr(OP_LUI, 6'd0, 0, 0, 0, 0);
    run_instr(OP_ORI, 6'd0, 0, 0, 0, 0);
    chk("ori_retired", retired, 32'd6);
    run_instr(OP_R, FN_SUB, 0, 0, 0, 0);
    run_instr(OP_R, FN_AND, 0, 1, 0, 0);
    run_instr(OP_R, FN_OR,  1, 0, 0, 0);
    run_instr(OP_R, FN_SLT, 0, 0, 0, 0);
    run_instr(OP_ADDI, 6'd0, 0, 0, 0, 0);
    run_instr(OP_ANDI, 6'd0, 0, 0, 0, 0);
    run_instr(OP_J, 6'd0, 0, 0, 0, 0);
    run_instr(OP_SW, 6'd0, 0, 0, 2, 0);
    chk("mix_retired", retired, 32'd14);

    // Illegal opcode traps into HALT
    run_instr(6'b111111, 6'd0, 0, 0, 0, 0);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_retired", retired, 32'd14);
    rst_n = 1'b0;
    #1;
    chk("halt_reset_retired", retired, 32'd0);
    chk("halt_reset_flag", {31'd0, halted}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_ret = 32'd0;
    #1;
    chk("restart_in_if", {31'd0, mem_rd}, 32'd1);
    @(posedge clk);
    #1;

    // Counter wrap on a retired sw
    force dut.r_retired = 32'hFFFF_FFFF;
    #1 release dut.r_retired;
    exp_ret = 32'hFFFF_FFFF;
    run_instr(OP_SW, 6'd0, 0, 0, 1, 0);
    chk("wrap_retired", retired, 32'd0);
    run_instr(OP_R, FN_ADD, 0, 0, 0, 0);

    // Reset during MEM of a sw cuts mem_we immediately
    run_instr(OP_SW, 6'd0, 0, 0, 1, 1);
    mem_ready = 1'b0;
    #1;
    chk("mem_we_before_reset", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mem_we_during_reset", {31'd0, mem_we}, 32'd0);
    chk("abort_reset_outputs", {16'd0, act_vec()}, 32'd0);
    chk("abort_reset_retired", retired, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_ret = 32'd0;
    run_instr(OP_R, FN_ADD, 0, 0, 0, 0);
    chk("post_abort_retired", retired, 32'd1);

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter ILLEGAL_TRAP, default 1, meaning 1 = illegal opcode/funct enters HALT and 0 = it is skipped and the next fetch starts.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port opcode  input  6  instruction[31:26] from the instruction register; valid from ID onward.
REQ-005 SHALL have port funct  input  6  instruction[5:0]; used only when opcode = 000000.
REQ-006 SHALL have port zero  input  1  ALU zero flag; valid in EXE.
REQ-007 SHALL have port mem_ready  input  1  memory handshake: access completes in a cycle where it is 1.
REQ-008 SHALL have port mem_rd  output  1  memory read strobe.
REQ-009 SHALL have port mem_we  output  1  memory write strobe.
REQ-010 SHALL have port ir_we  output  1  instruction register load.
REQ-011 SHALL have port pc_we  output  1  PC load.
REQ-012 SHALL have port pc_src  output  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target.
REQ-013 SHALL have port ext_op  output  2  immediate-extender mode: 00 = zero-extend, 01 = sign-extend, 10 = lui (imm<<16).
REQ-014 SHALL have port alu_src  output  1  ALU operand B: 0 = register, 1 = extended immediate.
REQ-015 SHALL have port alu_op  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 slt.
REQ-016 SHALL have port reg_dst  output  1  register write address: 1 = rd, 0 = rt.
REQ-017 SHALL have port mem_to_reg  output  1  write-back source: 1 = memory, 0 = ALU.
REQ-018 SHALL have port reg_we  output  1  register file write enable.
REQ-019 SHALL have port halted  output  1  1 while in HALT.
REQ-020 SHALL have port retired  output  32  count of completed instructions.

Function
REQ-021 SHALL implement FSM states IF, ID, EXE, MEM, WB, HALT; strobe outputs are decoded from the current state and from opcode/funct.
REQ-022 SHALL decode the following legal opcodes: R-type 000000, addi 001000, andi 001100, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010.
REQ-023 SHALL accept only R-type funct codes add 100000, sub 100010, and 100100, or 100101, slt 101010; any other opcode or funct is illegal.
REQ-024 In IF: SHALL assert mem_rd; in the cycle mem_ready = 1, SHALL assert ir_we and pc_we with pc_src = 00, then go to ID; otherwise SHALL stay in IF.
REQ-025 In ID: j SHALL assert pc_we with pc_src = 10, increment retired, and go to IF.
REQ-026 In ID: an illegal instruction SHALL go to HALT when ILLEGAL_TRAP = 1, otherwise to IF without incrementing retired.
REQ-027 In ID: all other instructions SHALL go to EXE.
REQ-028 ext_op SHALL be 01 for addi, lw, sw, beq; 00 for andi, ori; 10 for lui; and 00 for R-type, j, and in IF/HALT.
REQ-029 ext_op SHALL be held stable from ID through the last state of the instruction.
REQ-030 In EXE: alu_src SHALL be 1 for immediate, lw and sw instructions.
REQ-031 In EXE: alu_op SHALL be taken from funct for R-type; andi = 010, ori = 011, beq = 001; all other instructions use 000.
REQ-032 In EXE for beq: pc_we SHALL equal zero, with pc_src = 01; the block SHALL increment retired and go to IF.
REQ-033 In EXE: lw and sw SHALL go to MEM; all other instructions SHALL go to WB.
REQ-034 In MEM: SHALL assert mem_rd for lw or mem_we for sw and stay in MEM until mem_ready = 1.
REQ-035 On MEM completion: sw SHALL increment retired and go to IF; lw SHALL go to WB.
REQ-036 In WB: SHALL assert reg_we for one cycle, with reg_dst = 1 only for R-type and mem_to_reg = 1 only for lw; SHALL increment retired and go to IF.
REQ-037 HALT SHALL be absorbing until reset; in HALT, halted = 1 and all strobes are 0.
REQ-038 retired SHALL wrap from FFFFFFFF to 00000000 without any flag.
REQ-039 Every strobe (mem_rd, mem_we, ir_we, pc_we, reg_we) SHALL be at most one state wide and SHALL never be asserted outside its listed state.

Reset
REQ-040 While rst_n = 0: state SHALL be IF, retired = 0, halted = 0, and all strobes and select outputs SHALL be 0, regardless of clk.
REQ-041 Deassertion of rst_n mid-instruction SHALL restart at IF with no partial write issued.

Verification
REQ-042 add (opcode 000000, funct 100000) with mem_ready tied 1: states IF, ID, EXE, WB over 4 cycles; reg_we = 1, reg_dst = 1 in WB only; retired goes 0 to 1.
REQ-043 lw with mem_ready low for 3 cycles in MEM: stays in MEM for 4 cycles with mem_rd = 1; ext_op = 01; WB has mem_to_reg = 1; 8 cycles total.
REQ-044 beq with zero = 1 and zero = 0: pc_we = 1 with pc_src = 01 in EXE only when zero = 1; retired increments in both cases.
REQ-045 lui, then ori: ext_op = 10 during ID to WB for lui and 00 for ori; alu_op = 011 in EXE of ori.
REQ-046 Illegal opcode 111111 with ILLEGAL_TRAP = 1: HALT entered after ID, halted = 1, no strobes for 20 cycles; rst_n pulse returns to IF with retired = 0.
REQ-047 retired preloaded near FFFFFFFF (force or long run) plus one retired sw: wraps to 00000000; rst_n asserted during MEM drops mem_we immediately.
